// File: rtl/ir_pkg.sv
// ir_pkg: MIPS field positions, opcode constants and instruction-class encoding
package ir_pkg;
    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_MSB = 10;
    localparam int SHAMT_LSB = 6;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_MSB   = 15;
    localparam int IMM_LSB   = 0;
    localparam int JIDX_MSB  = 25;
    localparam int JIDX_LSB  = 0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    typedef enum logic [1:0] {
        ITYPE_R = 2'b00,
        ITYPE_I = 2'b01,
        ITYPE_J = 2'b10
    } itype_t;

    function automatic itype_t classify(input logic [5:0] op);
        return op == OP_RTYPE ? ITYPE_R : (op == OP_J || op == OP_JAL) ? ITYPE_J : ITYPE_I;
    endfunction
endpackage

// File: rtl/ir_skid_buf.sv
// ir_skid_buf: generic 2-entry valid/ready skid buffer with registered in_ready
module ir_skid_buf #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] head
);
    logic [1:0]   cnt;
    logic [1:0]   cnt_nxt;
    logic [W-1:0] skid;
    logic         acc;
    logic         dlv;

    assign acc       = in_valid && in_ready;
    assign dlv       = out_valid && out_ready;
    assign out_valid = cnt != 2'd0;

    // occupancy after this cycle's accept/deliver
    always_comb begin
        cnt_nxt = cnt + {1'b0, acc} - {1'b0, dlv};
    end

    // head refills from skid when full, otherwise from the input; skid only fills when head stays
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 2'd0;
            in_ready <= 1'b0;
            head     <= '0;
            skid     <= '0;
        end else begin
            cnt      <= cnt_nxt;
            in_ready <= cnt_nxt != 2'd2;
            if (dlv && cnt == 2'd2)
                head <= skid;
            else if (acc && (cnt == 2'd0 || dlv))
                head <= in_data;
            if (acc && cnt == 2'd1 && !dlv)
                skid <= in_data;
        end
    end
endmodule

// File: rtl/ir_field_split.sv
// ir_field_split: buffers instruction words and splits the head word into MIPS fields
// Optional SIGN_EXT_EN adds the sign-extended imm32 output.
module ir_field_split
    import ir_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      in_word,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       opcode,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [4:0]       shamt,
    output logic [5:0]       funct,
    output logic [15:0]      imm16,
    output logic [27:0]      jaddr28,
    output logic [1:0]       itype,
    output logic [CNT_W-1:0] jcount
`ifdef SIGN_EXT_EN
    ,
    output logic [31:0]      imm32
`endif
);
    logic [31:0] word;

    ir_skid_buf #(.W(32)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_word),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .head      (word)
    );

    assign opcode  = word[OPC_MSB:OPC_LSB];
    assign rs      = word[RS_MSB:RS_LSB];
    assign rt      = word[RT_MSB:RT_LSB];
    assign rd      = word[RD_MSB:RD_LSB];
    assign shamt   = word[SHAMT_MSB:SHAMT_LSB];
    assign funct   = word[FUNCT_MSB:FUNCT_LSB];
    assign imm16   = word[IMM_MSB:IMM_LSB];
    assign jaddr28 = {word[JIDX_MSB:JIDX_LSB], 2'b00};
    assign itype   = classify(opcode);

`ifdef SIGN_EXT_EN
    assign imm32 = {{16{imm16[15]}}, imm16};
`endif

    // count J-type words as they are handed downstream, wrapping silently
    always_ff @(posedge clk) begin
        if (rst)
            jcount <= '0;
        else if (out_valid && out_ready && itype == ITYPE_J)
            jcount <= jcount + 1'b1;
    end
endmodule
